// File: rtl/lfsr_period_check.sv
// Period checker for an external LFSR stage: loads a seed, counts steps until the
// stage reports a return to its seed (or gives up after 2^NUM_BITS steps), then reports.
module lfsr_period_check #(
   parameter int NUM_BITS = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [NUM_BITS-1:0] seed,
   input  logic [NUM_BITS-1:0] lfsr_data,
   input  logic                lfsr_done,
   output logic                lfsr_enable,
   output logic                lfsr_seed_dv,
   output logic [NUM_BITS-1:0] lfsr_seed,
   output logic                busy,
   output logic                result_valid,
   output logic [NUM_BITS:0]   period,
   output logic                pass,
   output logic                timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [NUM_BITS:0] CNT_FULL   = {1'b1, {NUM_BITS{1'b0}}};
   localparam logic [NUM_BITS:0] CNT_MAXLEN = CNT_FULL - (NUM_BITS+1)'(1);

   state_t                state_q, state_d;
   logic [NUM_BITS:0]     cnt_q, cnt_d;
   logic [NUM_BITS-1:0]   seed_q, seed_d;
   logic [NUM_BITS:0]     period_q, period_d;
   logic                  pass_q, pass_d;
   logic                  timeout_q, timeout_d;
   logic                  detect;
   logic                  expire;

   // The observed LFSR value is deliberately not used by any decision.
   logic                  unused_lfsr_data;
   assign unused_lfsr_data = ^lfsr_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         seed_q    <= '0;
         period_q  <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         seed_q    <= seed_d;
         period_q  <= period_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

   // cnt==0 is the cycle right after the seed load, where the stage trivially equals its seed.
   assign detect = (state_q == RUN) && (cnt_q != '0) && lfsr_done;
   assign expire = (state_q == RUN) && (cnt_q == CNT_FULL) && !detect;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      seed_d    = seed_q;
      period_d  = period_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               seed_d    = seed;
               cnt_d     = '0;
               period_d  = '0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         LOAD: begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            if (detect) begin
               state_d   = REPORT;
               period_d  = cnt_q;
               pass_d    = (cnt_q == CNT_MAXLEN);
               timeout_d = 1'b0;
            end else if (expire) begin
               state_d   = REPORT;
               period_d  = cnt_q;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + (NUM_BITS+1)'(1);
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs: strobes depend on the state register alone.
   assign lfsr_enable  = (state_q == LOAD) || (state_q == RUN);
   assign lfsr_seed_dv = (state_q == LOAD);
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == REPORT);
   assign lfsr_seed    = seed_q;
   assign period       = period_q;
   assign pass         = pass_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_lfsr_period_check.sv
// Bench for lfsr_period_check: a 5-bit XNOR LFSR stage model drives the DUT, and a
// timeline reference model predicts every output cycle by cycle.
module tb_lfsr_period_check;
   localparam int NB = 5;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          start = 1'b0;
   logic [NB-1:0] seed = '0;
   logic [NB-1:0] lfsr_data = '0;
   logic          lfsr_done;
   logic          lfsr_enable, lfsr_seed_dv, busy, result_valid, pass, timeout;
   logic [NB-1:0] lfsr_seed;
   logic [NB:0]   period;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 0;

   always #5 clk = ~clk;

   lfsr_period_check #(.NUM_BITS(NB)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
      .lfsr_data(lfsr_data), .lfsr_done(lfsr_done),
      .lfsr_enable(lfsr_enable), .lfsr_seed_dv(lfsr_seed_dv), .lfsr_seed(lfsr_seed),
      .busy(busy), .result_valid(result_valid), .period(period),
      .pass(pass), .timeout(timeout)
   );

   // External LFSR stage: x^5+x^3+1 XNOR, all-ones is the lock-up state.
   function automatic logic [NB-1:0] lf_next(input logic [NB-1:0] s);
      return {s[3:0], ~(s[4] ^ s[2])};
   endfunction

   logic [NB-1:0] lf_state = '0;
   logic [NB-1:0] lf_seed = '0;
   logic          no_done = 1'b0;

   always @(posedge clk) begin
      if (lfsr_enable) begin
         if (lfsr_seed_dv) begin
            lf_state <= lfsr_seed;
            lf_seed  <= lfsr_seed;
         end else begin
            lf_state <= lf_next(lf_state);
         end
      end
   end
   assign lfsr_done = !no_done && (lf_state == lf_seed);

   // Expected result: steps until return to the seed, giving up after 2^NB steps.
   function automatic void ref_result(input logic [NB-1:0] s, input logic nd,
                                      output int p, output bit ps, output bit to);
      logic [NB-1:0] x;
      bit found;
      x = s; found = 0; p = 32; ps = 0; to = 1;
      if (!nd) begin
         for (int k = 1; k <= 32; k++) begin
            x = lf_next(x);
            if (!found && x == s) begin
               found = 1; p = k; ps = (k == 31); to = 0;
            end
         end
      end
   endfunction

   // Timeline model: m_t = -1 idle, else cycles since the accepting edge (0 = load cycle).
   int            m_t = -1;
   int            m_p = 0;
   bit            m_ps = 0, m_tt = 0;
   logic [NB-1:0] m_seed = '0;
   int            m_period = 0;
   bit            m_pass_o = 0, m_to_o = 0;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_t = -1; m_seed = '0; m_period = 0; m_pass_o = 0; m_to_o = 0;
      end else if (m_t == -1) begin
         if (start) begin
            m_t = 0; m_seed = seed; m_period = 0; m_pass_o = 0; m_to_o = 0;
            ref_result(seed, no_done, m_p, m_ps, m_tt);
         end
      end else if (m_t == m_p + 2) begin
         m_t = -1;
      end else begin
         m_t++;
         if (m_t == m_p + 2) begin
            m_period = m_p; m_pass_o = m_ps; m_to_o = m_tt;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("busy", 64'(busy), 64'(m_t >= 0));
         chk("result_valid", 64'(result_valid), 64'(m_t >= 0 && m_t == m_p + 2));
         chk("lfsr_enable", 64'(lfsr_enable), 64'(m_t >= 0 && m_t < m_p + 2));
         chk("lfsr_seed_dv", 64'(lfsr_seed_dv), 64'(m_t == 0));
         chk("lfsr_seed", 64'(lfsr_seed), 64'(m_seed));
         chk("period", 64'(period), 64'(m_period));
         chk("pass", 64'(pass), 64'(m_pass_o));
         chk("timeout", 64'(timeout), 64'(m_to_o));
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_rv"}, 64'(result_valid), 64'd0);
      chk({tag, "_en"}, 64'(lfsr_enable), 64'd0);
      chk({tag, "_sdv"}, 64'(lfsr_seed_dv), 64'd0);
      chk({tag, "_seed"}, 64'(lfsr_seed), 64'd0);
      chk({tag, "_period"}, 64'(period), 64'd0);
      chk({tag, "_pass"}, 64'(pass), 64'd0);
      chk({tag, "_timeout"}, 64'(timeout), 64'd0);
   endtask

   // Returns at a falling edge with the model idle, so the next rising edge can accept.
   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (m_t != -1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (m_t != -1) begin
         checks++; failures++;
         $display("FAIL wait_idle: busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic run_check(input logic [NB-1:0] s, input bit wiggle, input int exp_edges,
                            input int exp_period, input bit exp_pass, input bit exp_to);
      int  edges;
      bit  seen;
      wait_idle();
      #1 start = 1'b1; seed = s;
      @(posedge clk);
      #1 start = 1'b0;
      edges = 0; seen = 0;
      while (!seen && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (result_valid) seen = 1;
         else if (wiggle) #1 seed = NB'($urandom);
      end
      chk("latency_edges", 64'(edges), 64'(exp_edges));
      chk("res_period", 64'(period), 64'(exp_period));
      chk("res_pass", 64'(pass), 64'(exp_pass));
      chk("res_timeout", 64'(timeout), 64'(exp_to));
      chk("res_seed", 64'(lfsr_seed), 64'(s));
   endtask

   initial begin
      int rv_cnt, idle_cnt;
      #1 reset_n = 1'b0;
      #2 chk_all_zero("reset");
      cmp_en = 1;
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b1;

      run_check(5'h01, 0, 33, 31, 1, 0);
      run_check(5'h1F, 0, 3, 1, 0, 0);
      wait_idle();
      no_done = 1'b1;
      run_check(5'h07, 0, 34, 32, 0, 1);
      no_done = 1'b0;
      run_check(5'h13, 1, 33, 31, 1, 0);

      // start held high: back-to-back checks with a single idle cycle between them
      wait_idle();
      #1 start = 1'b1; seed = 5'h05;
      @(negedge clk);
      rv_cnt = 0; idle_cnt = 0;
      for (int i = 0; i < 105; i++) begin
         if (!busy) idle_cnt++;
         if (result_valid) begin
            rv_cnt++;
            chk("b2b_period", 64'(period), 64'd31);
         end
         @(negedge clk);
      end
      #1 start = 1'b0;
      chk("b2b_reports", 64'(rv_cnt), 64'd3);
      chk("b2b_idle_cycles", 64'(idle_cnt), 64'd3);

      // abort mid-run at cnt=10
      wait_idle();
      #1 start = 1'b1; seed = 5'h03;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("abort");
      @(negedge clk);
      #2 reset_n = 1'b1;
      rv_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid) rv_cnt++;
      end
      chk("abort_no_result", 64'(rv_cnt), 64'd0);
      run_check(5'h0A, 0, 33, 31, 1, 0);

      // randomized traffic against the reference model
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         #1;
         lfsr_data = NB'($urandom);
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
         start = ($urandom_range(0, 3) == 0);
         seed  = ($urandom_range(0, 5) == 0) ? 5'h1F : NB'($urandom);
         if (m_t == -1 && $urandom_range(0, 7) == 0) no_done = ~no_done;
      end
      #1 start = 1'b0; reset_n = 1'b1;
      wait_idle();
      no_done = 1'b0;
      @(negedge clk);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/lfsr_period_check.md
LFSR_PERIOD_CHECK -- requirements
Module: lfsr_period_check

Interface
REQ-001 Parameter: NUM_BITS, default 5, width of the LFSR under test (legal 3..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a period check; sampled only in IDLE.
REQ-005 seed  input  NUM_BITS  seed for the check; captured when start is accepted.
REQ-006 lfsr_data  input  NUM_BITS  LFSR_Data from the lfsr stage; observation only.
REQ-007 lfsr_done  input  1  LFSR_Done from the lfsr stage (combinational state==seed compare).
REQ-008 lfsr_enable  output  1  drives the lfsr enable.
REQ-009 lfsr_seed_dv  output  1  drives the lfsr seed_dv.
REQ-010 lfsr_seed  output  NUM_BITS  drives the lfsr Seed_Data; holds the captured seed.
REQ-011 busy  output  1  high in LOAD, RUN and REPORT.
REQ-012 result_valid  output  1  one-cycle pulse when a result is available.
REQ-013 period  output  NUM_BITS+1  measured period in LFSR steps.
REQ-014 pass  output  1  period equals 2^NUM_BITS-1.
REQ-015 timeout  output  1  no return to the seed within 2^NUM_BITS steps.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and REPORT, held in a state register.
REQ-017 IDLE -> LOAD when start=1; the same edge SHALL capture seed into lfsr_seed, clear the step counter and clear pass, timeout and period.
REQ-018 In IDLE, start=0 SHALL hold IDLE; start in any other state SHALL be ignored, with no queueing.
REQ-019 LOAD SHALL last exactly one cycle, with lfsr_enable=1 and lfsr_seed_dv=1, then go to RUN.
REQ-020 RUN SHALL drive lfsr_enable=1 and lfsr_seed_dv=0; lfsr_enable and lfsr_seed_dv SHALL decode from the state register only (Moore).
REQ-021 Step counter cnt, NUM_BITS+1 bits wide: it SHALL be 0 on RUN entry and increment by 1 on every RUN edge that does not exit RUN.
REQ-022 Detection condition: state=RUN, cnt!=0 and lfsr_done=1. When it holds, the next edge SHALL register period=cnt, pass=(cnt==2^NUM_BITS-1), timeout=0 and go to REPORT.
REQ-023 Timeout condition: state=RUN, cnt==2^NUM_BITS and no detection. The next edge SHALL register period=cnt, pass=0, timeout=1 and go to REPORT.
REQ-024 If detection and timeout hold in the same cycle, detection SHALL take priority.
REQ-025 The lfsr stage advances one extra step on the exiting edge; the lfsr state after a check is unspecified and SHALL NOT affect the result.
REQ-026 REPORT SHALL last one cycle, with result_valid=1, then go to IDLE.
REQ-027 period, pass and timeout SHALL hold their values until the next accepted start.
REQ-028 lfsr_seed SHALL remain stable from capture until the next accepted start.
REQ-029 Latency: result_valid SHALL assert in the cycle after the (P+2)th rising edge following the edge that accepted start, where P is the measured period.
REQ-030 An all-ones seed (XNOR lock-up state) SHALL produce period=1, pass=0 and timeout=0; no special-case logic is required.
REQ-031 lfsr_data SHALL NOT influence any output.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state=IDLE, cnt=0 and lfsr_seed=0, and force busy, result_valid, lfsr_enable, lfsr_seed_dv, pass, timeout and period to 0.
REQ-033 Reset asserted mid-check SHALL abort the check without a result_valid pulse.
REQ-034 After reset_n rises, the first start SHALL be accepted on the first rising edge at which start=1.

Verification (NUM_BITS=5, real lfsr instance attached)
REQ-035 seed=5'h01, start pulse -> result_valid 33 edges after acceptance; period=31, pass=1, timeout=0.
REQ-036 seed=5'h1F -> result_valid 3 edges after acceptance; period=1, pass=0, timeout=0.
REQ-037 Behavioural lfsr model with lfsr_done tied 0 -> timeout=1, period=32, pass=0, result_valid 34 edges after acceptance.
REQ-038 start held high continuously -> checks run back-to-back, one per IDLE visit; each reports period=31; busy drops for exactly one cycle between checks.
REQ-039 reset_n pulsed low during RUN (cnt=10) -> all outputs 0 immediately, no result_valid; a subsequent start with seed=5'h0A -> period=31, pass=1.
REQ-040 seed changed while busy -> lfsr_seed unchanged; result period=31 for the originally captured seed.
